mul_div_sequencer: RTL and testbench

- Multi-cycle sequencer for the EX stage's multiply/divide resource (MULT, MULTU, DIV, DIVU).
- Accepts one request from ID/EX and iterates one bit per cycle: shift-add for multiply, restoring subtract for divide.
- Holds the HI/LO result registers and raises Busy so the hazard unit stalls later HI/LO consumers.
- The single-cycle ALU is untouched; this block runs beside it.

---
 rtl/mul_div_pkg.sv | 28 ++
 rtl/mul_div_step.sv | 44 ++++
 rtl/mul_div_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mul_div_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// ============================================================
// Module   : mul_div_pkg
// Desc     : Shared encodings and defaults for the MD sequencer.
// Revision : 1.0
// ============================================================
`default_nettype none

package mul_div_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ITER_COUNT     = DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mul_div_step.sv
// ============================================================
// Module   : mul_div_step
// Desc     : One combinational iteration: shift-add multiply or
//            restoring-subtract divide on the accumulator.
// Revision : 1.0
// ============================================================
`default_nettype none

module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    is_div_i,
  input  logic [2*DATA_WIDTH:0]   acc_i,
  input  logic [DATA_WIDTH-1:0]   opnd_i,
  output logic [2*DATA_WIDTH:0]   acc_o
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   w_sum;
  logic [W+1:0] w_diff;

  always_comb begin
    w_sum  = acc_i[2*W:W] + {1'b0, opnd_i};
    // acc_i[2W-1:W-1] is the upper half already shifted left by one.
    w_diff = {1'b0, acc_i[2*W-1:W-1]} - {2'b00, opnd_i};
    if (is_div_i) begin
      if (!w_diff[W+1]) begin
        acc_o = {w_diff[W:0], acc_i[W-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*W-1:0], 1'b0};
      end
    end else if (acc_i[0]) begin
      acc_o = {1'b0, w_sum, acc_i[W-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*W:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_div_sequencer.sv
// ============================================================
// Module   : mul_div_sequencer
// Desc     : Bit-serial MULT/MULTU/DIV/DIVU unit with HI/LO and Busy.
// Options  : MULDIV_EARLY_OUT_EN - multiply exits when multiplier is spent.
// Revision : 1.0
// ============================================================
`default_nettype none

module mul_div_sequencer
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = $clog2(ITER_COUNT) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [1:0]            MDOp,
  input  logic [DATA_WIDTH-1:0] InA,
  input  logic [DATA_WIDTH-1:0] InB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(W - 1);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 is_div_q;
  logic                 neg_q;
  logic                 sa_q;
  logic                 div0_q;
  logic [2*W:0]         acc_q;
  logic [2*W:0]         acc_d;
  logic [W-1:0]         opnd_q;
  logic [W-1:0]         a_raw_q;
`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [CNT_WIDTH-1:0] ITERS = CNT_WIDTH'(W);
  logic [W-1:0]         mplr_q;
`endif

  logic                 w_signed;
  logic                 w_sa;
  logic                 w_sb;
  logic [W-1:0]         w_abs_a;
  logic [W-1:0]         w_abs_b;
  logic                 w_early;
  logic [2*W-1:0]       w_prod_mag;
  logic [2*W-1:0]       w_prod;
  logic [W-1:0]         w_quo;
  logic [W-1:0]         w_rem;

  mul_div_step #(.DATA_WIDTH(W)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d)
  );

  always_comb begin
    w_signed = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    w_sa     = w_signed && InA[W-1];
    w_sb     = w_signed && InB[W-1];
    w_abs_a  = w_sa ? -InA : InA;
    w_abs_b  = w_sb ? -InB : InB;
`ifdef MULDIV_EARLY_OUT_EN
    w_early    = !is_div_q && (mplr_q == '0);
    // Remaining iterations would only shift, so apply them in one go.
    w_prod_mag = acc_q[2*W-1:0] >> (ITERS - cnt_q);
`else
    w_early    = 1'b0;
    w_prod_mag = acc_q[2*W-1:0];
`endif
    w_prod = neg_q ? -w_prod_mag : w_prod_mag;
    w_quo  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    w_rem  = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      div0_q    <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      mplr_q    <= '0;
`endif
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start && !Flush) begin
            state_q  <= S_RUN;
            Busy     <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= MDOp[1];
            neg_q    <= w_sa ^ w_sb;
            sa_q     <= w_sa;
            div0_q   <= MDOp[1] && (InB == '0);
            a_raw_q  <= InA;
            if (MDOp[1]) begin
              acc_q  <= {{(W+1){1'b0}}, w_abs_a};
              opnd_q <= w_abs_b;
            end else begin
              acc_q  <= {{(W+1){1'b0}}, w_abs_b};
              opnd_q <= w_abs_a;
            end
`ifdef MULDIV_EARLY_OUT_EN
            mplr_q <= w_abs_b;
`endif
          end
        end
        S_RUN: begin
          if (Flush) begin
            state_q <= S_IDLE;
            Busy    <= 1'b0;
          end else if (w_early) begin
            state_q <= S_FIX;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            mplr_q <= mplr_q >> 1;
`endif
            if (cnt_q == LAST_ITER) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          Busy    <= 1'b0;
          if (!Flush) begin
            Done <= 1'b1;
            if (is_div_q) begin
              DivByZero <= div0_q;
              // Divide by zero reports the untouched dividend.
              if (div0_q) begin
                Hi <= a_raw_q;
                Lo <= '1;
              end else begin
                Hi <= w_rem;
                Lo <= w_quo;
              end
            end else begin
              {Hi, Lo} <= w_prod;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_sequencer.sv
// ============================================================
// Module   : tb_mul_div_sequencer
// Desc     : Scoreboard bench for mul_div_sequencer (default build).
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_mul_div_sequencer;
  import mul_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [1:0]  MDOp = 2'b00;
  logic [31:0] InA = '0;
  logic [31:0] InB = '0;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          t0;
  } exp_t;

  exp_t sb[$];

  mul_div_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .MDOp      (MDOp),
    .InA       (InA),
    .InB       (InB),
    .Flush     (Flush),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Caller is at a negedge; Start is sampled at the next rising edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed);
    exp_t e;
    Start = 1'b1;
    MDOp  = op;
    InA   = a;
    InB   = b;
    if (push) begin
      e.hi  = eh;
      e.lo  = el;
      e.dbz = ed;
      e.t0  = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({nm, "_timeout"}, 64'(n), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input string nm);
    @(negedge clk);
    issue(op, a, b, 1'b1, eh, el, ed);
    wait_done(nm);
  endtask

  // Monitor: pops an expectation on every Done and checks value and timing.
  initial begin : monitor
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (Done) begin
        chk("busy_low_at_done", {63'd0, Busy}, 64'd0);
        chk("busy_len", 64'(run), 64'd33);
        if (sb.size() == 0) begin
          chk("done_without_request", {63'd0, Done}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", {32'd0, Hi}, {32'd0, e.hi});
          chk("lo", {32'd0, Lo}, {32'd0, e.lo});
          chk("divbyzero", {63'd0, DivByZero}, {63'd0, e.dbz});
          chk("latency", 64'(cyc - e.t0), 64'd33);
        end
      end
      if (Busy) run++;
      else run = 0;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_dbz",  {63'd0, DivByZero}, 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7");
    run_op(MD_MULT,  32'd5,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0, "mult_5xneg6");
    run_op(MD_MULT,  32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mult_min_x2");
    run_op(MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0, "divu_7_2");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7_2");
    run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, "div_7_neg2");
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, "div_ovf");
    run_op(MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, "divu_by0");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_neg_by0");

    // Starts during a running op must be ignored.
    @(negedge clk);
    issue(MD_MULTU, 32'h1234_5678, 32'h10, 1'b1, 32'h1, 32'h2345_6780, 1'b0);
    repeat (4) @(negedge clk);
    issue(MD_DIVU, 32'd9, 32'd3, 1'b0, '0, '0, 1'b0);
    repeat (14) @(negedge clk);
    issue(MD_MULT, 32'd11, 32'd13, 1'b0, '0, '0, 1'b0);
    wait_done("ignore_start");

    // Back-to-back: new Start in the Done cycle.
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "b2b_first");
    issue(MD_MULTU, 32'h0001_0001, 32'h0001_0001, 1'b1, 32'h1, 32'h0002_0001, 1'b0);
    wait_done("b2b_second");

    // Flush at iteration 10.
    @(negedge clk);
    issue(MD_DIVU, 32'd9, 32'd3, 1'b0, '0, '0, 1'b0);
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    chk("busy_after_flush", {63'd0, Busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("hilo_after_flush", {Hi, Lo}, 64'h0000_0001_0002_0001);

    // Flush together with Start drops the request.
    Start = 1'b1;
    Flush = 1'b1;
    MDOp  = MD_MULTU;
    InA   = 32'd6;
    InB   = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    Flush = 1'b0;
    chk("busy_flush_start", {63'd0, Busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("hilo_flush_start", {Hi, Lo}, 64'h0000_0001_0002_0001);

    // Asynchronous reset at iteration 20.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b0);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {63'd0, Busy}, 64'd0);
    chk("async_rst_done", {63'd0, Done}, 64'd0);
    chk("async_rst_hilo", {Hi, Lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "post_rst_multu");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
